quad_term_accum_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational three-term polynomial adder in the Quadratic Approximation Unit.
- Sums t2 + t1 + (t0 << SHIFT0) as signed two's complement.
- Input and output use valid/ready handshakes, two register stages, and full backpressure.
- Overflow is detected per result (pulse) and accumulated (sticky).
- Sits between the term multipliers and the result formatter.

---
 rtl/quad_term_accum_pipe.sv | 110 +++++++++++
 tb/tb_quad_term_accum_pipe.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/quad_term_accum_pipe.sv
// ============================================================================
// Module   : quad_term_accum_pipe
// Brief    : Two-stage valid/ready pipeline computing t2 + t1 + (t0 << SHIFT0)
//            with per-result and sticky overflow. Optional: QUAD_ACC_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quad_term_accum_pipe #(
  parameter int W0     = 10,
  parameter int W1     = 18,
  parameter int W2     = 22,
  parameter int SHIFT0 = 4,
  parameter int SW     = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W0-1:0] t0,
  input  logic signed [W1-1:0] t1,
  input  logic signed [W2-1:0] t2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [SW-1:0] s,
  output logic                 ovf,
  output logic                 ovf_sticky,
  input  logic                 clr_ovf
);

  localparam int IW_A = (W2 > W1) ? W2 : W1;
  localparam int IW_B = ((W0 + SHIFT0) > IW_A) ? (W0 + SHIFT0) : IW_A;
  localparam int IW   = IW_B + 2;

  logic                 s1_valid;
  logic signed [IW-1:0] p1;
  logic signed [IW-1:0] a0;
  logic signed [IW-1:0] full;
  logic                 adv2;
  logic                 accept;
  logic                 ovf_next;
  logic signed [SW-1:0] s_wrap;
  logic signed [SW-1:0] s_next;

  assign adv2     = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || adv2;
  assign accept   = in_valid && in_ready;
  assign full     = p1 + a0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      p1       <= '0;
      a0       <= '0;
    end else begin
      if (accept) begin
        p1 <= {{(IW-W2){t2[W2-1]}}, t2} + {{(IW-W1){t1[W1-1]}}, t1};
        a0 <= {{(IW-W0){t0[W0-1]}}, t0} << SHIFT0;
      end
      s1_valid <= accept ? 1'b1 : (adv2 ? 1'b0 : s1_valid);
    end
  end

  // Result fits iff every bit above the output sign bit matches it.
  generate
    if (SW < IW) begin : g_narrow
      assign ovf_next = !((&full[IW-1:SW-1]) || !(|full[IW-1:SW-1]));
      assign s_wrap   = full[SW-1:0];
    end else begin : g_wide
      assign ovf_next = 1'b0;
      assign s_wrap   = SW'(full);
    end
  endgenerate

`ifdef QUAD_ACC_SATURATE_EN
  localparam logic signed [SW-1:0] S_MAX = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [SW-1:0] S_MIN = {1'b1, {(SW-1){1'b0}}};
  assign s_next = !ovf_next ? s_wrap : (full[IW-1] ? S_MIN : S_MAX);
`else
  assign s_next = s_wrap;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      ovf       <= 1'b0;
    end else if (adv2) begin
      out_valid <= 1'b1;
      s         <= s_next;
      ovf       <= ovf_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A flagged transfer outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid && out_ready && ovf) begin
      ovf_sticky <= 1'b1;
    end else if (clr_ovf) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_quad_term_accum_pipe.sv
// ============================================================================
// Module   : tb_quad_term_accum_pipe
// Brief    : Directed bench with model-driven scoreboard for quad_term_accum_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_quad_term_accum_pipe;

  localparam int W0 = 10, W1 = 18, W2 = 22, SHIFT0 = 4, SW = 22;

  typedef struct {
    logic [SW-1:0] s;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, ovf, ovf_sticky, clr_ovf;
  logic signed [W0-1:0] t0;
  logic signed [W1-1:0] t1;
  logic signed [W2-1:0] t2;
  logic signed [SW-1:0] s;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  quad_term_accum_pipe #(.W0(W0), .W1(W1), .W2(W2), .SHIFT0(SHIFT0), .SW(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .t0(t0), .t1(t1), .t2(t2), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .ovf(ovf), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(int a0, int a1, int a2);
    exp_t   r;
    longint full, mx, mn;
    full  = longint'(a2) + longint'(a1) + (longint'(a0) <<< SHIFT0);
    mx    = (64'sd1 <<< (SW - 1)) - 1;
    mn    = -(64'sd1 <<< (SW - 1));
    r.ovf = (full > mx) || (full < mn);
    r.s   = full[SW-1:0];
`ifdef QUAD_ACC_SATURATE_EN
    if (r.ovf) r.s = (full > 0) ? mx[SW-1:0] : mn[SW-1:0];
`endif
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Scoreboard: push on accept, pop on transfer (both seen at the negedge before the edge).
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_output observed=%0d expected=none", s);
        end
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          assert (s === e.s && ovf === e.ovf) else begin
            errors++;
            $error("FAIL output observed s=%0d ovf=%0b expected s=%0d ovf=%0b",
                   s, ovf, $signed(e.s), e.ovf);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(int'(t0), int'(t1), int'(t2)));
    end
  end

  task automatic drive(int a0, int a1, int a2);
    in_valid = 1'b1;
    t0 = W0'(a0);
    t1 = W1'(a1);
    t2 = W2'(a2);
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send(int a0, int a1, int a2);
    drive(a0, a1, a2);
    wait_accept();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
    t0 = '0; t1 = '0; t2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Basic sum and two-cycle latency
    @(posedge clk); #1 send(5, 100, -3);
    @(negedge clk);
    chk("latency_1cyc", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_2cyc", 32'(out_valid), 32'd1);
    chk("basic_s", 32'(s), 32'(SW'(177)));
    chk("basic_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);

    // Overflow extremes
    @(posedge clk); #1 send(511, 131071, 2097151);
    repeat (3) @(negedge clk);
    chk("pos_ovf_sticky", 32'(ovf_sticky), 32'd1);
    @(posedge clk); #1 send(-512, -131072, -2097152);
    repeat (3) @(negedge clk);
    chk("neg_ovf_sticky", 32'(ovf_sticky), 32'd1);
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", 32'(ovf_sticky), 32'd0);

    // Set wins over clear in the transfer cycle
    @(posedge clk); #1 drive(511, 131071, 2097151);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(negedge clk);
    chk("set_clr_transfer", 32'(out_valid && out_ready && ovf), 32'd1);
    @(posedge clk); #1 clr_ovf = 1'b0;
    @(negedge clk);
    chk("set_wins_clr", 32'(ovf_sticky), 32'd1);
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    @(negedge clk);
    chk("clr_no_ovf", 32'(ovf_sticky), 32'd0);

    // Backpressure: two accepted, third held off while out_ready is low
    @(posedge clk); #1 out_ready = 1'b0;
    send(1, 0, 0);
    send(2, 0, 0);
    drive(3, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_s_held", 32'(s), 32'd16);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_accept();
    send(4, 0, 0);
    repeat (4) @(negedge clk);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset with two results in flight
    @(posedge clk); #1 out_ready = 1'b0;
    send(7, 0, 0);
    send(8, 0, 0);
    @(posedge clk); #3 rst = 1'b1;
    #1 chk("rst_async_out_valid", 32'(out_valid), 32'd0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_stale_output", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1 send(1, 1, 1);
    repeat (2) @(negedge clk);
    chk("post_rst_s", 32'(s), 32'd18);
    repeat (2) @(negedge clk);
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
